// File: rtl/register_writeback_if.sv
// Write-back request and memory-return signals between the pipeline and the register bank.
// master drives requests and load data; slave is the register write side.
interface register_writeback_if;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_reg;
    logic [15:0] wb_data;
    logic        wb_is_load;
    logic        mem_valid;
    logic [15:0] mem_data;

    modport master (
        output wb_valid,
        output wb_reg,
        output wb_data,
        output wb_is_load,
        output mem_valid,
        output mem_data,
        input  wb_ready
    );

    modport slave (
        input  wb_valid,
        input  wb_reg,
        input  wb_data,
        input  wb_is_load,
        input  mem_valid,
        input  mem_data,
        output wb_ready
    );
endinterface

// File: rtl/register_writeback.sv
// Write side of the 8 x 16-bit register bank: one-cycle ALU commits, blocking loads with
// timeout, read-hazard detection against the outstanding load destination.
module register_writeback #(
    parameter int unsigned TIMEOUT = 16,
    parameter bit          R0_ZERO = 1'b1
) (
    input  logic                clock,
    input  logic                reset_n,
    register_writeback_if.slave bus,
    input  logic [4:0]          rd_sel,
    output logic [15:0]         r0,
    output logic [15:0]         r1,
    output logic [15:0]         r2,
    output logic [15:0]         r3,
    output logic [15:0]         r4,
    output logic [15:0]         r5,
    output logic [15:0]         r6,
    output logic [15:0]         r7,
    output logic                busy,
    output logic [2:0]          pending_reg,
    output logic                hazard,
    output logic                bad_reg,
    output logic                timeout,
    output logic [15:0]         wr_count
);

    typedef enum logic {StIdle, StWaitMem} state_e;

    localparam logic [7:0] LastWait = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] regs_q [8];
    logic [2:0]  pending_q, pending_d;
    logic [7:0]  wait_q, wait_d;
    logic        bad_q, bad_d;
    logic        to_q, to_d;
    logic [15:0] count_q, count_d;

    logic        accept;
    logic        we;
    logic        commit;
    logic [2:0]  waddr;
    logic [15:0] wdata;

    assign bus.wb_ready = (state_q == StIdle);
    assign accept       = bus.wb_valid && bus.wb_ready;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        wait_d    = wait_q;
        bad_d     = 1'b0;
        to_d      = 1'b0;
        we        = 1'b0;
        waddr     = bus.wb_reg[2:0];
        wdata     = bus.wb_data;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (bus.wb_reg > 5'd7) begin
                        bad_d = 1'b1;
                    end else if (bus.wb_is_load) begin
                        pending_d = bus.wb_reg[2:0];
                        wait_d    = 8'd0;
                        state_d   = StWaitMem;
                    end else begin
                        we = 1'b1;
                    end
                end
            end
            StWaitMem: begin
                waddr = pending_q;
                wdata = bus.mem_data;
                // Returning data takes priority over an expiring timeout.
                if (bus.mem_valid) begin
                    we        = 1'b1;
                    pending_d = 3'd0;
                    state_d   = StIdle;
                end else if (wait_q == LastWait) begin
                    pending_d = 3'd0;
                    wait_d    = 8'd0;
                    to_d      = 1'b1;
                    state_d   = StIdle;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
        endcase
    end

    // A write to a hardwired-zero r0 completes but neither stores nor counts.
    assign commit  = we && !(R0_ZERO && (waddr == 3'd0));
    assign count_d = commit ? count_q + 16'd1 : count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            pending_q <= 3'd0;
            wait_q    <= 8'd0;
            bad_q     <= 1'b0;
            to_q      <= 1'b0;
            count_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            wait_q    <= wait_d;
            bad_q     <= bad_d;
            to_q      <= to_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 16'd0;
            end
        end else if (commit) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign r0 = regs_q[0];
    assign r1 = regs_q[1];
    assign r2 = regs_q[2];
    assign r3 = regs_q[3];
    assign r4 = regs_q[4];
    assign r5 = regs_q[5];
    assign r6 = regs_q[6];
    assign r7 = regs_q[7];

    assign busy        = (state_q == StWaitMem);
    assign pending_reg = pending_q;
    assign hazard      = busy && (rd_sel <= 5'd7) && (rd_sel[2:0] == pending_q);
    assign bad_reg     = bad_q;
    assign timeout     = to_q;
    assign wr_count    = count_q;

endmodule

// File: tb/tb_register_writeback.sv
// Scoreboard bench: the driver pushes the expected post-edge view from a behavioural model,
// the monitor pops and compares one snapshot after every rising edge.
module tb_register_writeback;
    localparam int unsigned TIMEOUT = 16;
    localparam bit          R0_ZERO = 1'b1;

    typedef struct packed {
        logic [7:0][15:0] r;
        logic [15:0]      cnt;
        logic             busy;
        logic [2:0]       pend;
        logic             bad;
        logic             to;
        logic             ready;
        logic             hazard;
    } snap_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [4:0] rd_sel = 5'd0;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic busy, hazard, bad_reg, timeout;
    logic [2:0] pending_reg;
    logic [15:0] wr_count;

    int checks = 0;
    int errors = 0;
    snap_t exp_q[$];

    // Behavioural model state
    logic [15:0] m_r [8];
    logic [15:0] m_cnt;
    bit          m_busy, m_bad, m_to;
    int          m_pend, m_wait;

    always #5 clock = ~clock;

    register_writeback_if bus ();

    register_writeback #(.TIMEOUT(TIMEOUT), .R0_ZERO(R0_ZERO)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus), .rd_sel(rd_sel),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .busy(busy), .pending_reg(pending_reg), .hazard(hazard), .bad_reg(bad_reg),
        .timeout(timeout), .wr_count(wr_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_snap(input snap_t e, input string tag);
        logic [7:0][15:0] dr;
        dr = {r7, r6, r5, r4, r3, r2, r1, r0};
        for (int i = 0; i < 8; i++) chk($sformatf("%s r%0d", tag, i), 32'(dr[i]), 32'(e.r[i]));
        chk({tag, " wr_count"}, 32'(wr_count), 32'(e.cnt));
        chk({tag, " busy"}, 32'(busy), 32'(e.busy));
        chk({tag, " pending_reg"}, 32'(pending_reg), 32'(e.pend));
        chk({tag, " bad_reg"}, 32'(bad_reg), 32'(e.bad));
        chk({tag, " timeout"}, 32'(timeout), 32'(e.to));
        chk({tag, " wb_ready"}, 32'(bus.wb_ready), 32'(e.ready));
        chk({tag, " hazard"}, 32'(hazard), 32'(e.hazard));
    endtask

    function automatic snap_t model_snap(input logic [4:0] rs);
        snap_t s;
        for (int i = 0; i < 8; i++) s.r[i] = m_r[i];
        s.cnt    = m_cnt;
        s.busy   = m_busy;
        s.pend   = 3'(m_pend);
        s.bad    = m_bad;
        s.to     = m_to;
        s.ready  = !m_busy;
        s.hazard = m_busy && (int'(rs) == m_pend);
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 16'd0;
        m_cnt = 16'd0; m_busy = 0; m_bad = 0; m_to = 0; m_pend = 0; m_wait = 0;
    endtask

    task automatic model_commit(input int dst, input logic [15:0] d);
        if (!(R0_ZERO && dst == 0)) begin
            m_r[dst] = d;
            m_cnt    = m_cnt + 16'd1;
        end
    endtask

    // One clock of stimulus; the model advances and the expected result is queued.
    task automatic cycle(input bit v, input logic [4:0] wr, input logic [15:0] wd, input bit ld,
                         input bit mv, input logic [15:0] md, input logic [4:0] rs);
        @(negedge clock);
        reset_n        = 1'b1;
        bus.wb_valid   = v;
        bus.wb_reg     = wr;
        bus.wb_data    = wd;
        bus.wb_is_load = ld;
        bus.mem_valid  = mv;
        bus.mem_data   = md;
        rd_sel         = rs;
        m_bad = 0;
        m_to  = 0;
        if (!m_busy) begin
            if (v) begin
                if (wr > 7) m_bad = 1;
                else if (ld) begin m_busy = 1; m_pend = int'(wr); m_wait = 0; end
                else model_commit(int'(wr), wd);
            end
        end else if (mv) begin
            model_commit(m_pend, md);
            m_busy = 0;
            m_pend = 0;
        end else begin
            m_wait++;
            if (m_wait == int'(TIMEOUT)) begin m_busy = 0; m_pend = 0; m_to = 1; end
        end
        exp_q.push_back(model_snap(rs));
    endtask

    task automatic idle(input int n, input logic [4:0] rs);
        for (int i = 0; i < n; i++) cycle(0, 5'd0, 16'd0, 0, 0, 16'd0, rs);
    endtask

    task automatic do_reset();
        @(negedge clock);
        bus.wb_valid  = 1'b0;
        bus.mem_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_snap(model_snap(rd_sel), "async_reset");
        exp_q.push_back(model_snap(rd_sel));
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) compare_snap(exp_q.pop_front(), "mon");
        end
    end

    initial begin
        bus.wb_valid = 0; bus.wb_reg = 0; bus.wb_data = 0; bus.wb_is_load = 0;
        bus.mem_valid = 0; bus.mem_data = 0;
        model_reset();
        #3;
        compare_snap(model_snap(rd_sel), "reset");

        // ALU write
        cycle(1, 5'd3, 16'h1234, 0, 0, 16'd0, 5'd0);
        idle(1, 5'd0);
        // Load to r5, data after 3 waiting cycles, probing hazard
        cycle(1, 5'd5, 16'hAAAA, 1, 0, 16'd0, 5'd5);
        cycle(0, 5'd0, 16'd0, 0, 0, 16'd0, 5'd5);
        cycle(1, 5'd1, 16'h7777, 0, 0, 16'd0, 5'd4);
        cycle(0, 5'd0, 16'd0, 0, 0, 16'd0, 5'd13);
        cycle(0, 5'd0, 16'd0, 0, 1, 16'hBEEF, 5'd5);
        idle(1, 5'd5);
        // Timeout to r2, then data on the final waiting cycle
        cycle(1, 5'd2, 16'd0, 1, 0, 16'd0, 5'd2);
        idle(int'(TIMEOUT) + 1, 5'd2);
        cycle(1, 5'd2, 16'd0, 1, 0, 16'd0, 5'd2);
        idle(int'(TIMEOUT) - 1, 5'd2);
        cycle(0, 5'd0, 16'd0, 0, 1, 16'h5A5A, 5'd2);
        idle(1, 5'd0);
        // Invalid destination and hardwired r0
        cycle(1, 5'd9, 16'h1111, 0, 0, 16'd0, 5'd0);
        cycle(1, 5'd0, 16'hFFFF, 0, 0, 16'd0, 5'd0);
        cycle(1, 5'd0, 16'hFFFF, 1, 0, 16'd0, 5'd0);
        cycle(0, 5'd0, 16'd0, 0, 1, 16'h4321, 5'd8);
        idle(1, 5'd0);
        // Reset mid-load, then stray memory data while idle
        cycle(1, 5'd6, 16'd0, 1, 0, 16'd0, 5'd6);
        idle(2, 5'd6);
        do_reset();
        cycle(0, 5'd0, 16'd0, 0, 1, 16'hDEAD, 5'd6);
        idle(1, 5'd6);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) < 60), 5'($urandom_range(0, 9)), 16'($urandom),
                  ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 20), 16'($urandom),
                  5'($urandom_range(0, 15)));
        end
        idle(int'(TIMEOUT) + 1, 5'd0);

        // Counter wrap
        while (m_cnt != 16'hFFFF) cycle(1, 5'($urandom_range(1, 7)), 16'($urandom), 0, 0, 16'd0, 5'd0);
        cycle(1, 5'd7, 16'h0F0F, 0, 0, 16'd0, 5'd0);
        idle(2, 5'd0);

        repeat (3) @(negedge clock);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
